// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit, 2-bit-field microprocessor.
// Holds the sequencer state encoding, opcode constants, instruction field
// positions and the sign-extension helpers used by the controller and the
// datapath.
package cpu_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Opcodes in ir[7:6]
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  // Instruction field positions: {op[7:6], rs[5:4], rt[3:2], rd/imm[1:0]}
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int JOFF_MSB = 5;  // jump offset occupies ir[5:0]

  // Sign-extend the 2-bit immediate to a byte
  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

  // Sign-extend the 6-bit jump offset to a byte
  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder shared by the sequencer and the datapath.
// Ports:
//   op_i       opcode field ir[7:6]
//   reg_dst_o  1 = write rd (ADD), 0 = write rt
//   alu_src_o  1 = ALU operand B is sext(imm2) (LOAD/STORE)
//   is_mem_o   instruction accesses data memory
//   is_load_o  instruction is a LOAD
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [1:0] op_i,
  output logic       reg_dst_o,
  output logic       alu_src_o,
  output logic       is_mem_o,
  output logic       is_load_o
);

  // Opcode to control-class map; JUMP leaves everything low
  always_comb begin
    reg_dst_o = 1'b0;
    alu_src_o = 1'b0;
    is_mem_o  = 1'b0;
    is_load_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        reg_dst_o = 1'b1;
      end
      OP_LOAD: begin
        alu_src_o = 1'b1;
        is_mem_o  = 1'b1;
        is_load_o = 1'b1;
      end
      OP_STORE: begin
        alu_src_o = 1'b1;
        is_mem_o  = 1'b1;
      end
      default: begin
        reg_dst_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: owns the PC, latches the instruction word and issues
// Moore-style datapath control from registered decodes of state and ir.
// Optional single-step gating of FETCH is built with MULTICYCLE_CTRL_STEP_EN.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   run                   leave IDLE and start at pc=0
//   step (optional)       rising edge admits one instruction
//   instr                 instruction memory data for address pc
//   dmem_ready            data memory completion
//   pc, ir                instruction address and latched instruction
//   reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg  controls
//   busy, halted, error   status (error is sticky memory timeout)
//   retired               saturating count of completed instructions
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int PROG_LEN    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef MULTICYCLE_CTRL_STEP_EN
  input  logic             step,
`endif
  input  logic [7:0]       instr,
  input  logic             dmem_ready,
  output logic [7:0]       pc,
  output logic [7:0]       ir,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  localparam int             TMO_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [7:0]     PROG_LEN_C = 8'(PROG_LEN);

  state_e             state_q, state_d;
  logic [7:0]         pc_q, pc_d, ir_q, ir_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               error_q, error_d;
  logic               ret_inc_s, go_s;
  logic               reg_write_q, reg_dst_q, alu_src_q, mem_read_q;
  logic               mem_write_q, mem_to_reg_q, busy_q, halted_q;
  logic               reg_dst_d, alu_src_d;
  logic               dec_reg_dst_s, dec_alu_src_s, dec_is_mem_s, dec_is_load_s;

  ctrl_decode u_decode (
    .op_i      (ir_q[OP_MSB:OP_LSB]),
    .reg_dst_o (dec_reg_dst_s),
    .alu_src_o (dec_alu_src_s),
    .is_mem_o  (dec_is_mem_s),
    .is_load_o (dec_is_load_s)
  );

`ifdef MULTICYCLE_CTRL_STEP_EN
  logic step_q, step_pend_q, step_pend_d, step_rise_s;

  // A step edge seen outside FETCH is held until FETCH consumes it
  assign step_rise_s = step & ~step_q;
  assign go_s        = step_rise_s | step_pend_q;

  // Pending-step bookkeeping
  always_comb begin
    step_pend_d = step_pend_q | step_rise_s;
    if (state_q == ST_FETCH) begin
      step_pend_d = 1'b0;
    end else begin
      step_pend_d = step_pend_q | step_rise_s;
    end
  end

  // Registered step copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= step;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign go_s = 1'b1;
`endif

  // Next-state, PC, IR, timeout and retire-count logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    tmo_d     = tmo_q;
    error_d   = error_q;
    ret_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (!go_s) begin
          state_d = ST_FETCH;
        end else if (pc_q >= PROG_LEN_C) begin
          state_d = ST_HALT;
        end else begin
          ir_d    = instr;
          pc_d    = pc_q + 8'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ir_q[OP_MSB:OP_LSB] == OP_JUMP) begin
          // pc already points past the jump, so the offset is relative to it
          pc_d      = pc_q + sext6(ir_q[JOFF_MSB:0]);
          ret_inc_s = 1'b1;
          state_d   = ST_FETCH;
        end else if (dec_is_mem_s) begin
          tmo_d   = '0;
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (dec_is_load_s) begin
            state_d = ST_WB;
          end else begin
            ret_inc_s = 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          // This is the MEM_TIMEOUT-th cycle without ready
          error_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        ret_inc_s = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ret_inc_s && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end

    // Operand selects are captured during DECODE and held afterwards
    if (state_q == ST_DECODE) begin
      reg_dst_d = dec_reg_dst_s;
      alu_src_d = dec_alu_src_s;
    end else begin
      reg_dst_d = reg_dst_q;
      alu_src_d = alu_src_q;
    end
  end

  // State and registered Moore outputs; strobes are decoded from the
  // upcoming state so they are valid for the whole state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= 8'd0;
      ir_q         <= 8'd0;
      tmo_q        <= '0;
      retired_q    <= '0;
      error_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      tmo_q        <= tmo_d;
      retired_q    <= retired_d;
      error_q      <= error_d;
      reg_write_q  <= (state_d == ST_WB);
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= (state_d == ST_MEM) && dec_is_load_s;
      mem_write_q  <= (state_d == ST_MEM) && !dec_is_load_s;
      mem_to_reg_q <= (state_d == ST_WB) && dec_is_load_s;
      busy_q       <= (state_d != ST_IDLE) && (state_d != ST_HALT);
      halted_q     <= (state_d == ST_HALT);
    end
  end

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign reg_write  = reg_write_q;
  assign reg_dst    = reg_dst_q;
  assign alu_src    = alu_src_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign error      = error_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
`ifdef MULTICYCLE_CTRL_STEP_EN
  logic        step;
`endif
  logic [7:0]  instr;
  logic        dmem_ready;
  logic [7:0]  pc;
  logic [7:0]  ir;
  logic        reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg;
  logic        busy, halted, error;
  logic [15:0] retired;

  logic [7:0]  imem [0:255];
  int          total;
  int          passed;
  int          cnt;

  multicycle_ctrl #(.PROG_LEN(4), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
`ifdef MULTICYCLE_CTRL_STEP_EN
    .step       (step),
`endif
    .instr      (instr),
    .dmem_ready (dmem_ready),
    .pc         (pc),
    .ir         (ir),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .busy       (busy),
    .halted     (halted),
    .error      (error),
    .retired    (retired)
  );

  assign instr = imem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    run        = 1'b0;
    dmem_ready = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
`ifdef MULTICYCLE_CTRL_STEP_EN
    step = 1'b0;
`endif

    // Reset state: {reg_write,reg_dst,alu_src,mem_read,mem_write,mem_to_reg,busy,halted,error}
    do_reset();
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir, 8'h00);
    check("rst_retired", retired, 16'd0);
    check("rst_ctrl", {reg_write, reg_dst, alu_src, mem_read, mem_write,
                       mem_to_reg, busy, halted, error}, 9'd0);

`ifdef MULTICYCLE_CTRL_STEP_EN
    // Step mode: three ADDs, run held high, two step pulses
    imem[0] = 8'h14; imem[1] = 8'h14; imem[2] = 8'h14;
    run = 1'b1;
    tick(5);
    check("step_wait_pc", pc, 8'h00);
    check("step_wait_busy", busy, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(9);
    end
    tick(5);
    check("step_retired", retired, 16'd2);
    check("step_pc", pc, 8'h02);
    check("step_busy", busy, 1'b1);
    check("step_halted", halted, 1'b0);
    run = 1'b0;
`else
    // Program ADD, LOAD, ADD, JUMP +2 with memory always ready
    imem[0] = 8'h14; imem[1] = 8'h49; imem[2] = 8'h2A; imem[3] = 8'hC2;
    dmem_ready = 1'b1;
    start();                                   // FETCH of pc 0
    check("p_fetch_busy", busy, 1'b1);
    check("p_fetch_pc", pc, 8'h00);
    tick(1);                                   // DECODE
    check("p_dec_pc", pc, 8'h01);
    check("p_dec_ir", ir, 8'h14);
    tick(1);                                   // EXEC of ADD
    check("p_add_sel", {reg_dst, alu_src}, 2'b10);
    tick(1);                                   // WB of ADD
    check("p_add_wb", {reg_write, mem_to_reg}, 2'b10);
    tick(1);                                   // FETCH pc 1
    check("p_add_done", {reg_write, 15'd0, retired}, {1'b0, 15'd0, 16'd1});
    tick(3);                                   // MEM of LOAD
    check("p_ld_mem", {mem_read, mem_write, reg_dst, alu_src}, 4'b1001);
    tick(1);                                   // WB of LOAD
    check("p_ld_wb", {reg_write, mem_to_reg, mem_read}, 3'b110);
    tick(8);                                   // FETCH after JUMP
    check("p_jump_pc", pc, 8'h06);
    check("p_jump_retired", retired, 16'd4);
    check("p_jump_busy", {busy, halted}, 2'b10);
    tick(1);                                   // halting FETCH done
    check("p_halt", {busy, halted, error}, 3'b010);
    run = 1'b1;
    tick(3);
    run = 1'b0;
    check("p_halt_absorb", {halted, pc}, {1'b1, 8'h06});

    // LOAD with three wait cycles
    do_reset();
    imem[0] = 8'h49;
    start();
    tick(2);                                   // EXEC
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (mem_read) cnt++;
      if (i == 3) dmem_ready = 1'b1;
    end
    check("ld_wait_reads", cnt, 4);
    tick(1);
    check("ld_wait_wb", {reg_write, mem_to_reg, mem_read}, 3'b110);
    dmem_ready = 1'b0;
    tick(1);
    check("ld_wait_after", {reg_write, mem_to_reg, 14'd0, retired}, {2'b00, 14'd0, 16'd1});

    // STORE timeout
    do_reset();
    imem[0] = 8'h80;
    start();
    tick(2);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (mem_write && !error) cnt++;
    end
    check("st_tmo_writes", cnt, 15);
    tick(1);
    check("st_tmo_halt", {error, halted, mem_write, busy}, 4'b1100);
    dmem_ready = 1'b1;
    tick(2);
    check("st_tmo_sticky", {error, halted, 14'd0, retired}, {2'b11, 14'd0, 16'd0});
    dmem_ready = 1'b0;

    // Backward JUMP at pc 0 wraps to 255 then halts
    do_reset();
    imem[0] = 8'hFE;
    start();
    tick(3);                                   // FETCH after JUMP
    check("jmp_wrap_pc", pc, 8'hFF);
    check("jmp_wrap_ret", retired, 16'd1);
    tick(1);
    check("jmp_wrap_halt", {halted, pc}, {1'b1, 8'hFF});

    // Reset in the middle of a LOAD memory wait
    do_reset();
    imem[0] = 8'h14; imem[1] = 8'h49;
    start();
    tick(7);                                   // MEM of LOAD
    check("mid_mem_pre", {mem_read, pc, retired}, {1'b1, 8'h02, 16'd1});
    reset = 1'b1;
    tick(1);
    check("mid_mem_rst", {mem_read, busy, halted, error, pc, retired}, 28'd0);
    reset = 1'b0;
    tick(2);
    check("mid_mem_idle", {busy, pc}, 9'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
